bcd_scan_display: RTL and testbench

- Downstream consumer of the 60-count BCD counter output (packed tens/units nibbles).
- Time-multiplexes NUM_DIGITS BCD digits onto one shared 7-segment bus plus per-digit enables.
- Contains a snapshot latch, a scan prescaler, a digit-index counter and a BLANK/DRIVE slot FSM for anti-ghosting.
- All pin outputs are registered.

---
 rtl/bcd_disp_pkg.sv | 25 ++
 rtl/bcd_scan_display_seg7_decode.sv | 27 ++
 rtl/bcd_scan_display.sv | 137 +++++++++++++
 tb/tb_bcd_scan_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD scan display: active-high 7-segment codes
// and the slot state encoding.
package bcd_disp_pkg;

  localparam int unsigned SEG_W = 7;

  // Active-high segment codes, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_e;

endpackage

// File: rtl/bcd_scan_display_seg7_decode.sv
// Combinational BCD to active-high 7-segment decoder; invalid BCD (10..15)
// decodes to all segments off.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed BCD 7-segment scanner with snapshot latch and per-slot
// anti-ghosting blank. Optional macro BCD_SCAN_LEADING_ZERO_BLANK_EN.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned COMMON_ANODE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;

  localparam logic                  INV        = (COMMON_ANODE != 0);
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF    = {8{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{INV}};

  logic [BCD_W-1:0]      snap_bcd;
  logic [NUM_DIGITS-1:0] snap_dp;
  logic [PRESC_W-1:0]    presc;
  logic [PRESC_W-1:0]    presc_next;
  logic                  presc_wrap;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  blank_next;
  slot_e                 state;

  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [SEG_W-1:0]      dec_seg;
  logic [7:0]            drive_seg;
  logic [NUM_DIGITS-1:0] drive_an;

  // Prescaler and digit-index sequencing.
  always_comb begin
    presc_wrap = (presc == PRESC_LAST);
    presc_next = presc_wrap ? '0 : presc + PRESC_W'(1);
    idx_next   = idx;
    if (presc_wrap) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Slot is blank while the upcoming prescaler value is below the blank window.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_next = 1'b0;
    end else begin : g_blank
      assign blank_next = (presc_next < PRESC_W'(BLANK_CYCLES));
    end
  endgenerate

  // Snapshot, prescaler, index and slot FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_bcd <= '0;
      snap_dp  <= '0;
      presc    <= '0;
      idx      <= '0;
      state    <= SLOT_BLANK;
    end else begin
      if (load) begin
        snap_bcd <= bcd_in;
        snap_dp  <= dp_in;
      end
      presc <= presc_next;
      idx   <= idx_next;
      case (state)
        SLOT_BLANK: if (!blank_next) state <= SLOT_DRIVE;
        SLOT_DRIVE: if (blank_next)  state <= SLOT_BLANK;
      endcase
    end
  end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic higher_zero;
    lz_mask     = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      higher_zero = higher_zero && (snap_bcd[4*k +: 4] == 4'd0);
      lz_mask[k]  = higher_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Select the snapshot digit at the current scan index.
  always_comb begin
    cur_bcd = 4'd0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_bcd = snap_bcd[4*k +: 4];
        cur_dp  = snap_dp[k];
        cur_lz  = lz_mask[k];
      end
    end
  end

  seg7_decode u_decode (
    .bcd   (cur_bcd),
    .seg_c (dec_seg)
  );

  assign drive_seg = {cur_dp, (cur_lz ? SEG_BLANK : dec_seg)};
  assign drive_an  = NUM_DIGITS'(1) << idx;

  // Registered pin outputs; XOR with the off pattern applies polarity.
  always_ff @(posedge clk) begin
    if (rst || (state == SLOT_BLANK)) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= drive_seg ^ SEG_OFF;
      an  <= drive_an ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: directed table, slot timing,
// mid-slot reset and randomized traffic against a cycle-count reference model.
module tb_bcd_scan_display;

  localparam int unsigned ND  = 2;
  localparam int unsigned DIV = 4;
  localparam int unsigned BLK = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] bcd_in;
  logic [1:0] dp_in;
  logic [7:0] seg, seg_ca;
  logic [1:0] an, an_ca;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: edges since reset and the model snapshot.
  int         n;
  logic [7:0] msnap;
  logic [1:0] mdp;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic       r;
    logic       l;
    logic [7:0] b;
    logic [1:0] d;
    logic [1:0] a;
    logic [7:0] s;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  bcd_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .COMMON_ANODE(0)
  ) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg), .an(an)
  );

  bcd_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYCLES(BLK), .COMMON_ANODE(1)
  ) dut_ca (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .seg(seg_ca), .an(an_ca)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Output after the next edge follows the slot position reached n edges after reset.
  function automatic void model_out(output logic [1:0] ea, output logic [7:0] es);
    int         p, dig;
    logic [7:0] rest;
    logic [3:0] v;
    logic [6:0] s7;
    ea = 2'b00;
    es = 8'h00;
    p   = n % DIV;
    dig = (n / DIV) % ND;
    if (n == 0 || p < BLK) return;
    rest = msnap >> (4 * dig);
    v    = rest[3:0];
    s7   = (v < 4'd10) ? seg_tab[v] : 7'h00;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    if (dig > 0 && rest == 8'h00) s7 = 7'h00;
`endif
    es = {mdp[dig], s7};
    ea = 2'(1 << dig);
  endfunction

  task automatic tick(input logic r, input logic l, input logic [7:0] b, input logic [1:0] d);
    logic [1:0] ea;
    logic [7:0] es;
    rst = r; load = l; bcd_in = b; dp_in = d;
    @(posedge clk);
    if (r) begin
      ea = 2'b00; es = 8'h00; n = 0; msnap = 8'h00; mdp = 2'b00;
    end else begin
      model_out(ea, es);
      n++;
      if (l) begin msnap = b; mdp = d; end
    end
    #1;
    check("model_an",    {6'b0, an},    {6'b0, ea});
    check("model_seg",   seg,           es);
    check("model_an_ca", {6'b0, an_ca}, {6'b0, ~ea});
    check("model_seg_ca", seg_ca,       ~es);
  endtask

  task automatic add(input logic r, input logic l, input logic [7:0] b,
                     input logic [1:0] d, input logic [1:0] a, input logic [7:0] s);
    vec_t v;
    v.r = r; v.l = l; v.b = b; v.d = d; v.a = a; v.s = s;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rise0[$], rise1[$];
    int   blanks;
    logic [1:0] prev;
    logic found;

    rst = 1'b1; load = 1'b0; bcd_in = 8'h00; dp_in = 2'b00;
    n = 0; msnap = 8'h00; mdp = 2'b00;

    // Reset, 59 display, invalid nibble with dp, snapshot hold and reload.
    add(1, 0, 8'h00, 2'b00, 2'b00, 8'h00);
    add(0, 1, 8'h59, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h59, 2'b00, 2'b01, 8'h6F);
    add(0, 1, 8'h59, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h59, 2'b00, 2'b10, 8'h6D);
    add(0, 1, 8'h3C, 2'b01, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 1, 8'h3C, 2'b01, 2'b01, 8'h80);
    add(0, 1, 8'h3C, 2'b01, 2'b00, 8'h00);
    add(0, 1, 8'h3C, 2'b01, 2'b10, 8'h4F);
    add(0, 1, 8'h42, 2'b00, 2'b10, 8'h4F);
    add(0, 0, 8'h17, 2'b00, 2'b10, 8'h66);
    add(0, 0, 8'h17, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h17, 2'b00, 2'b01, 8'h5B);
    add(0, 0, 8'h17, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h17, 2'b00, 2'b10, 8'h66);
    add(0, 1, 8'h17, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h99, 2'b00, 2'b01, 8'h07);
    add(0, 0, 8'h99, 2'b00, 2'b00, 8'h00);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h99, 2'b00, 2'b10, 8'h06);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].l, tbl[i].b, tbl[i].d);
      check("tbl_an",  {6'b0, an}, {6'b0, tbl[i].a});
      check("tbl_seg", seg,        tbl[i].s);
    end

    // Slot timing over two frames.
    blanks = 0;
    prev   = an;
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 8'h99, 2'b00);
      if (an == 2'b00) blanks++;
      if (an[0] && !prev[0]) rise0.push_back(i);
      if (an[1] && !prev[1]) rise1.push_back(i);
      prev = an;
    end
    check("blank_cycles", 8'(blanks), 8'd4);
    check("rise0_count",  8'(rise0.size()), 8'd2);
    if (rise0.size() == 2) check("frame_period", 8'(rise0[1] - rise0[0]), 8'd8);
    if (rise0.size() > 0 && rise1.size() > 0)
      check("slot_period", 8'(rise1[0] - rise0[0]), 8'd4);

    // Reset during a digit-1 drive cycle.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(0, 1, 8'h59, 2'b00);
      if (an == 2'b10) found = 1'b1;
    end
    check("find_digit1", {7'b0, found}, 8'd1);
    tick(1, 0, 8'h59, 2'b00);
    check("rst_an",     {6'b0, an},    8'h00);
    check("rst_seg",    seg,           8'h00);
    check("rst_an_ca",  {6'b0, an_ca}, 8'h03);
    check("rst_seg_ca", seg_ca,        8'hFF);
    tick(0, 1, 8'h59, 2'b00);
    check("post_rst_blank_an", {6'b0, an}, 8'h00);
    tick(0, 0, 8'h59, 2'b00);
    check("post_rst_an",  {6'b0, an}, 8'h01);
    check("post_rst_seg", seg,        8'h6F);

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    tick(1, 0, 8'h00, 2'b00);
    tick(0, 1, 8'h05, 2'b00);
    tick(0, 0, 8'h05, 2'b00);
    check("lz_d0_seg", seg, 8'h6D);
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h05, 2'b00);
    tick(0, 0, 8'h05, 2'b00);
    check("lz_d1_an",  {6'b0, an}, 8'h02);
    check("lz_d1_seg", seg,        8'h00);
    tick(1, 0, 8'h00, 2'b00);
    tick(0, 1, 8'h00, 2'b00);
    tick(0, 0, 8'h00, 2'b00);
    check("lz_zero_d0_seg", seg, 8'h3F);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      b[3:0] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      b[7:4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), b,
           2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
